// File: rtl/dll_tap_ctrl_pkg.sv
// Shared types for the DLL tap controller: FSM states and step-direction encoding.
package dll_tap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACQ    = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    // DIR_NONE marks "no step taken since start", so the first step is neither
    // a reversal nor a same-direction step.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

endpackage

// File: rtl/dll_tap_ctrl_if.sv
// Control/status bundle between the PHY clocking logic and the DLL tap controller.
interface dll_tap_ctrl_if #(
    parameter int NUM_TAPS = 64
);
    localparam int CODE_W = $clog2(NUM_TAPS);

    logic                start;
    logic                pd_late;
    logic                ovr_en;
    logic [CODE_W-1:0]   ovr_code;
    logic [CODE_W-1:0]   tap_code;
    logic [NUM_TAPS-1:0] sel_n;
    logic [NUM_TAPS-1:0] en;
    logic                locked;
    logic                sat;

    modport master (
        output start, pd_late, ovr_en, ovr_code,
        input  tap_code, sel_n, en, locked, sat
    );

    modport slave (
        input  start, pd_late, ovr_en, ovr_code,
        output tap_code, sel_n, en, locked, sat
    );

endinterface

// File: rtl/dll_therm_decode.sv
// Tap code to delay-chain controls: sel_n is a thermometer (i < code), en also
// enables the turnaround element itself (i <= code). Purely combinational.
module dll_therm_decode #(
    parameter int NUM_TAPS = 64,
    parameter int CODE_W   = $clog2(NUM_TAPS)
) (
    input  logic [CODE_W-1:0]   code,
    output logic [NUM_TAPS-1:0] sel_n,
    output logic [NUM_TAPS-1:0] en
);

    // Bit i of ones_shl is set exactly for i >= code.
    logic [NUM_TAPS-1:0] ones_shl;

    assign ones_shl = {NUM_TAPS{1'b1}} << code;

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign sel_n[gi] = ~ones_shl[gi];
        assign en[gi]    = ~ones_shl[gi] | (code == CODE_W'(gi));
    end

endmodule

// File: rtl/dll_tap_ctrl.sv
// Closed-loop DLL tap controller: synchronizes the phase-detector decision,
// filters it into up/down votes, steps the tap code and tracks lock.
module dll_tap_ctrl
    import dll_tap_ctrl_pkg::*;
#(
    parameter int NUM_TAPS   = 64,
    parameter int INIT_CODE  = 32,
    parameter int FILT_TH    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_CNT   = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    dll_tap_ctrl_if.slave bus
);

    localparam int CODE_W = $clog2(NUM_TAPS);
    localparam int ACC_W  = $clog2(FILT_TH) + 2;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int LCK_W  = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0]       MAX_CODE    = CODE_W'(NUM_TAPS - 1);
    localparam logic [CODE_W-1:0]       INIT_C      = CODE_W'(INIT_CODE);
    localparam logic signed [ACC_W-1:0] TH_POS      = ACC_W'(FILT_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG      = ACC_W'(-FILT_TH);
    localparam logic [SET_W-1:0]        SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [LCK_W-1:0]        LOCK_MAX    = LCK_W'(LOCK_CNT);

    state_e                  state_q, state_d;
    dir_e                    last_dir_q, last_dir_d;
    logic [CODE_W-1:0]       code_q, code_d;
    logic [NUM_TAPS-1:0]     sel_n_q, sel_n_d, en_q, en_d, sel_rst, en_rst;
    logic                    locked_q, locked_d, sat_q, sat_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_inc;
    logic [SET_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic [LCK_W-1:0]        rev_cnt_q, rev_cnt_d, same_cnt_q, same_cnt_d;
    logic [LCK_W-1:0]        rev_inc, same_inc;
    logic                    pd_meta_q, pd_s_q;
    logic [CODE_W-1:0]       ovr_clamped;
    logic                    step_req, at_limit;
    dir_e                    step_dir;

    // Override codes beyond the chain are only possible when NUM_TAPS is not a power of two.
    if (NUM_TAPS == (1 << CODE_W)) begin : g_no_clamp
        assign ovr_clamped = bus.ovr_code;
    end else begin : g_clamp
        assign ovr_clamped = (bus.ovr_code > MAX_CODE) ? MAX_CODE : bus.ovr_code;
    end

    // Outputs are decoded from the next code so they update on the same edge as tap_code.
    dll_therm_decode #(.NUM_TAPS(NUM_TAPS), .CODE_W(CODE_W)) u_dec (
        .code  (code_d),
        .sel_n (sel_n_d),
        .en    (en_d)
    );

    // Constant decode of the reset code, used as the flop reset value.
    dll_therm_decode #(.NUM_TAPS(NUM_TAPS), .CODE_W(CODE_W)) u_dec_rst (
        .code  (INIT_C),
        .sel_n (sel_rst),
        .en    (en_rst)
    );

    // Two-flop synchronizer for the asynchronous phase-detector output.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pd_meta_q <= 1'b0;
            pd_s_q    <= 1'b0;
        end else begin
            pd_meta_q <= bus.pd_late;
            pd_s_q    <= pd_meta_q;
        end
    end

    // Vote filter outcome and saturating counter increments for this cycle.
    always_comb begin
        acc_inc  = pd_s_q ? (acc_q - ACC_W'(1)) : (acc_q + ACC_W'(1));
        step_req = (acc_inc == TH_POS) || (acc_inc == TH_NEG);
        step_dir = (acc_inc == TH_POS) ? DIR_UP : DIR_DOWN;
        at_limit = (step_dir == DIR_UP) ? (code_q == MAX_CODE) : (code_q == '0);
        rev_inc  = (rev_cnt_q == LOCK_MAX) ? rev_cnt_q : rev_cnt_q + LCK_W'(1);
        same_inc = (same_cnt_q == LOCK_MAX) ? same_cnt_q : same_cnt_q + LCK_W'(1);
    end

    // FSM next state, code stepping, lock tracking and saturation flag.
    always_comb begin
        state_d      = state_q;
        last_dir_d   = last_dir_q;
        code_d       = code_q;
        locked_d     = locked_q;
        sat_d        = sat_q;
        acc_d        = acc_q;
        settle_cnt_d = settle_cnt_q;
        rev_cnt_d    = rev_cnt_q;
        same_cnt_d   = same_cnt_q;
        if (bus.ovr_en) begin
            code_d   = ovr_clamped;
            locked_d = 1'b0;
            state_d  = ST_IDLE;
        end else if (bus.start) begin
            code_d       = INIT_C;
            sat_d        = 1'b0;
            locked_d     = 1'b0;
            rev_cnt_d    = '0;
            same_cnt_d   = '0;
            last_dir_d   = DIR_NONE;
            acc_d        = '0;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SETTLE: begin
                    acc_d = '0;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        state_d      = locked_q ? ST_LOCKED : ST_ACQ;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
                ST_ACQ, ST_LOCKED: begin
                    acc_d = acc_inc;
                    if (step_req) begin
                        acc_d = '0;
                        if (at_limit) begin
                            // End of chain: flag it and keep voting at the same code.
                            sat_d = 1'b1;
                        end else begin
                            code_d       = (step_dir == DIR_UP) ? code_q + CODE_W'(1)
                                                                : code_q - CODE_W'(1);
                            state_d      = ST_SETTLE;
                            settle_cnt_d = '0;
                            last_dir_d   = step_dir;
                            if (last_dir_q != DIR_NONE) begin
                                if (step_dir != last_dir_q) begin
                                    rev_cnt_d  = rev_inc;
                                    same_cnt_d = '0;
                                end else begin
                                    same_cnt_d = same_inc;
                                    rev_cnt_d  = '0;
                                end
                            end
                            if (rev_cnt_d == LOCK_MAX) begin
                                locked_d = 1'b1;
                            end
                            if (state_q == ST_LOCKED && same_cnt_d == LOCK_MAX) begin
                                locked_d  = 1'b0;
                                rev_cnt_d = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Controller state registers; outputs return to the reset decode asynchronously.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            last_dir_q   <= DIR_NONE;
            code_q       <= INIT_C;
            sel_n_q      <= sel_rst;
            en_q         <= en_rst;
            locked_q     <= 1'b0;
            sat_q        <= 1'b0;
            acc_q        <= '0;
            settle_cnt_q <= '0;
            rev_cnt_q    <= '0;
            same_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            code_q       <= code_d;
            sel_n_q      <= sel_n_d;
            en_q         <= en_d;
            locked_q     <= locked_d;
            sat_q        <= sat_d;
            acc_q        <= acc_d;
            settle_cnt_q <= settle_cnt_d;
            rev_cnt_q    <= rev_cnt_d;
            same_cnt_q   <= same_cnt_d;
        end
    end

    assign bus.tap_code = code_q;
    assign bus.sel_n    = sel_n_q;
    assign bus.en       = en_q;
    assign bus.locked   = locked_q;
    assign bus.sat      = sat_q;

endmodule

// File: tb/tb_dll_tap_ctrl.sv
// Testbench for dll_tap_ctrl: directed scenarios plus random phase-detector
// traffic, compared every cycle against a behavioural model of the loop rules.
module tb_dll_tap_ctrl;

    localparam int NUM_TAPS   = 64;
    localparam int CODE_W     = 6;
    localparam int INIT_CODE  = 32;
    localparam int FILT_TH    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int LOCK_CNT   = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    always #5 HCLK = ~HCLK;

    dll_tap_ctrl_if #(.NUM_TAPS(NUM_TAPS)) bus ();

    dll_tap_ctrl #(
        .NUM_TAPS   (NUM_TAPS),
        .INIT_CODE  (INIT_CODE),
        .FILT_TH    (FILT_TH),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int thr    = 20;
    bit loop_en = 1'b0;

    // Behavioural model: mode 0 = holding, 1 = waiting after a code change, 2 = voting.
    int m_code, m_mode, m_wait, m_votes;
    bit m_locked, m_sat, m_p1, m_p2;
    int m_dirs[$];

    task automatic model_reset();
        m_code = INIT_CODE; m_mode = 0; m_wait = 0; m_votes = 0;
        m_locked = 1'b0; m_sat = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
        m_dirs.delete();
    endtask

    task automatic model_step();
        bit s;
        int dir, alt, run, nxt;
        s = m_p2;
        m_p2 = m_p1;
        m_p1 = bus.pd_late;
        if (bus.ovr_en) begin
            m_code = int'(bus.ovr_code);
            if (m_code > NUM_TAPS - 1) m_code = NUM_TAPS - 1;
            m_locked = 1'b0;
            m_mode = 0;
        end else if (bus.start) begin
            m_code = INIT_CODE; m_sat = 1'b0; m_locked = 1'b0;
            m_dirs.delete(); m_votes = 0; m_wait = 0; m_mode = 1;
        end else if (m_mode == 1) begin
            m_wait++;
            if (m_wait == SETTLE_CYC) begin
                m_wait = 0; m_votes = 0; m_mode = 2;
            end
        end else if (m_mode == 2) begin
            m_votes += s ? -1 : 1;
            if (m_votes == FILT_TH || m_votes == -FILT_TH) begin
                dir = (m_votes > 0) ? 1 : -1;
                m_votes = 0;
                nxt = m_code + dir;
                if (nxt < 0 || nxt > NUM_TAPS - 1) begin
                    m_sat = 1'b1;
                end else begin
                    m_code = nxt;
                    m_dirs.push_back(dir);
                    m_mode = 1; m_wait = 0;
                    alt = 0;
                    for (int i = m_dirs.size() - 1; i > 0 && m_dirs[i] != m_dirs[i-1]; i--) alt++;
                    run = 0;
                    for (int i = m_dirs.size() - 1; i > 0 && m_dirs[i] == m_dirs[i-1]; i--) run++;
                    if (!m_locked && alt >= LOCK_CNT) m_locked = 1'b1;
                    else if (m_locked && run >= LOCK_CNT) m_locked = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_sel(input int c);
        logic [63:0] r;
        for (int i = 0; i < NUM_TAPS; i++) r[i] = (i < c);
        return r;
    endfunction

    function automatic logic [63:0] exp_en(input int c);
        logic [63:0] r;
        for (int i = 0; i < NUM_TAPS; i++) r[i] = (i <= c);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_band(input string tag, input int lo);
        int c;
        c = int'(bus.tap_code);
        checks++;
        assert (c == lo || c == lo + 1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d or %0d", tag, c, lo, lo + 1);
        end
    endtask

    task automatic check_all();
        chk("tap_code", 64'(bus.tap_code), 64'(m_code));
        chk("sel_n", bus.sel_n, exp_sel(m_code));
        chk("en", bus.en, exp_en(m_code));
        chk("locked", 64'(bus.locked), 64'(m_locked));
        chk("sat", 64'(bus.sat), 64'(m_sat));
    endtask

    task automatic cycle();
        @(posedge HCLK);
        if (HRESETn) model_step();
        else model_reset();
        @(negedge HCLK);
        check_all();
        if (loop_en) bus.pd_late = (int'(bus.tap_code) >= thr);
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(bus.locked);
            1:       return int'(bus.sat);
            default: return int'(bus.tap_code);
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int val, input int budget);
        int n;
        n = 0;
        while (sig(sel) != val && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        assert (sig(sel) == val) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d after %0d cycles", tag, sig(sel), val, n);
        end
        $display("wait %s: reached after %0d cycles", tag, n);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    int bias, r, rnd_code;

    initial begin
        bus.start = 1'b0; bus.pd_late = 1'b0; bus.ovr_en = 1'b0; bus.ovr_code = '0;
        model_reset();

        // Reset and idle hold
        repeat (3) cycle();
        HRESETn = 1'b1;
        chk("rst_code", 64'(bus.tap_code), 64'd32);
        chk("rst_sel_n", bus.sel_n, 64'h0000_0000_FFFF_FFFF);
        chk("rst_en", bus.en, 64'h0000_0001_FFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
            bus.pd_late = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("idle_code", 64'(bus.tap_code), 64'd32);
        $display("step reset/idle: code=%0d", bus.tap_code);

        // Acquire lock with the delay-line threshold at 20
        loop_en = 1'b1; thr = 20;
        pulse_start();
        wait_for("lock", 0, 1, 700);
        for (int i = 0; i < 100; i++) begin
            cycle();
            chk_band("lock_band", 19);
        end
        chk("lock_hold", 64'(bus.locked), 64'd1);
        $display("step lock: code=%0d locked=%0b", bus.tap_code, bus.locked);

        // Threshold jump forces same-direction steps, then relock at 39/40
        thr = 40;
        wait_for("lose_lock", 0, 0, 200);
        wait_for("relock", 0, 1, 800);
        for (int i = 0; i < 60; i++) begin
            cycle();
            chk_band("relock_band", 39);
        end
        $display("step relock: code=%0d locked=%0b", bus.tap_code, bus.locked);

        // Override while locked; start is ignored and release keeps the code
        bus.ovr_en = 1'b1; bus.ovr_code = 6'd5; bus.start = 1'b1;
        cycle();
        chk("ovr_code", 64'(bus.tap_code), 64'd5);
        chk("ovr_en_vec", bus.en, 64'h0000_0000_0000_003F);
        chk("ovr_locked", 64'(bus.locked), 64'd0);
        repeat (3) cycle();
        bus.start = 1'b0; bus.ovr_en = 1'b0;
        repeat (30) cycle();
        chk("ovr_release", 64'(bus.tap_code), 64'd5);
        $display("step override: code=%0d", bus.tap_code);

        // Override mid-acquisition with a random code
        pulse_start();
        repeat (10) cycle();
        rnd_code = int'($urandom_range(0, NUM_TAPS - 1));
        bus.ovr_en = 1'b1; bus.ovr_code = CODE_W'(rnd_code);
        cycle();
        chk("ovr_acq_code", 64'(bus.tap_code), 64'(rnd_code));
        bus.ovr_en = 1'b0;
        repeat (10) cycle();
        chk("ovr_acq_hold", 64'(bus.tap_code), 64'(rnd_code));
        $display("step override mid-acq: code=%0d", bus.tap_code);

        // Random phase-detector traffic with occasional start and override
        loop_en = 1'b0;
        pulse_start();
        bias = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) bias = int'($urandom_range(10, 90));
            bus.pd_late = (int'($urandom_range(0, 99)) < bias);
            r = int'($urandom_range(0, 399));
            bus.start = (r < 2);
            if (!bus.ovr_en && r == 399) begin
                bus.ovr_en = 1'b1;
                bus.ovr_code = CODE_W'($urandom_range(0, NUM_TAPS - 1));
            end else if (bus.ovr_en && r < 150) begin
                bus.ovr_en = 1'b0;
            end
            cycle();
        end
        bus.start = 1'b0; bus.ovr_en = 1'b0;
        $display("step random: code=%0d locked=%0b sat=%0b", bus.tap_code, bus.locked, bus.sat);

        // Saturation at the top of the chain
        bus.pd_late = 1'b0;
        pulse_start();
        wait_for("sat_up", 1, 1, 600);
        chk("sat_up_code", 64'(bus.tap_code), 64'd63);
        chk("sat_up_sel_n", bus.sel_n, 64'h7FFF_FFFF_FFFF_FFFF);
        repeat (30) cycle();
        chk("sat_up_hold", 64'(bus.tap_code), 64'd63);
        pulse_start();
        chk("sat_clear", 64'(bus.sat), 64'd0);
        chk("sat_restart", 64'(bus.tap_code), 64'd32);
        $display("step saturate up: code=%0d", bus.tap_code);

        // Saturation at the bottom, step back up, then async reset mid-settle
        bus.pd_late = 1'b1;
        pulse_start();
        wait_for("sat_dn", 1, 1, 600);
        chk("sat_dn_code", 64'(bus.tap_code), 64'd0);
        bus.pd_late = 1'b0;
        wait_for("climb_1", 2, 1, 100);
        cycle();
        cycle();
        #2 HRESETn = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_code", 64'(bus.tap_code), 64'd32);
        chk("arst_sat", 64'(bus.sat), 64'd0);
        chk("arst_sel_n", bus.sel_n, 64'h0000_0000_FFFF_FFFF);
        cycle();
        cycle();
        HRESETn = 1'b1;
        repeat (5) cycle();
        $display("step async reset: code=%0d sat=%0b", bus.tap_code, bus.sat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
